// File: rtl/async_mem_sequencer.sv
// async_mem_sequencer: turns strobe-driven asynchronous SRAM-style accesses
// from the pads into single Wishbone classic master cycles. The pad strobes
// are resynchronised into clk. Address and write data are captured when a
// request is decoded. Read data is held on mem_d_o for as long as the master
// keeps oe_n/ce_n low.
module async_mem_sequencer #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_ce_n,
  input  logic            mem_we_n,
  input  logic            mem_oe_n,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_d_i,
  output logic [DW-1:0]   mem_d_o,
  output logic            mem_d_oe,
  output logic            mem_wait,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW-1:0]   wb_dat_i,
  output logic            wb_we_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  output logic            err_o
);

  // Last count value before a hung Wishbone cycle is forcibly terminated.
  // With this value, cyc is high for exactly TIMEOUT cycles.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_RD_REQ,
    S_RD_HOLD,
    S_WAIT_REL
  } state_t;

  // Strobe synchronisers, bit order {ce, we, oe}; idle (high) out of reset.
  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic          ce_s;
  logic          we_s;
  logic          oe_s;

  state_t        state_q;
  logic [15:0]   cnt_q;
  logic          cyc_q;
  logic          we_q;
  logic          wait_q;
  logic          doe_q;
  logic          err_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wdat_q;
  logic [DW-1:0] rdat_q;

  logic          wr_req;
  logic          rd_req;
  logic          term;

  assign ce_s = sync2_q[2];
  assign we_s = sync2_q[1];
  assign oe_s = sync2_q[0];

  // A write takes precedence when we_n and oe_n are both low.
  assign wr_req = !ce_s && !we_s;
  assign rd_req = !ce_s && !oe_s && we_s;

  // Any of ack, err or the timeout ends the cycle. Ack decides the outcome if
  // several of these coincide.
  assign term = wb_ack_i || wb_err_i || (cnt_q == TO_LAST);

  // Two-flop resync of the asynchronous pad strobes into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= {mem_ce_n, mem_we_n, mem_oe_n};
      sync2_q <= sync1_q;
    end
  end

  // Transaction sequencer: one Wishbone cycle per strobe assertion; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      wait_q  <= 1'b0;
      doe_q   <= 1'b0;
      err_q   <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wr_req) begin
            adr_q   <= mem_addr;
            wdat_q  <= mem_d_i;
            we_q    <= 1'b1;
            cyc_q   <= 1'b1;
            wait_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_WR_REQ;
          end else if (rd_req) begin
            adr_q   <= mem_addr;
            we_q    <= 1'b0;
            cyc_q   <= 1'b1;
            wait_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_RD_REQ;
          end
        end
        S_WR_REQ: begin
          if (term) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            wait_q  <= 1'b0;
            err_q   <= !wb_ack_i;
            state_q <= S_WAIT_REL;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_RD_REQ: begin
          if (term) begin
            cyc_q  <= 1'b0;
            wait_q <= 1'b0;
            err_q  <= !wb_ack_i;
            // If the master has already let go of the read, the data has
            // nowhere to go, so it is dropped.
            if (!ce_s && !oe_s) begin
              rdat_q  <= wb_ack_i ? wb_dat_i : '1;
              state_q <= S_RD_HOLD;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_RD_HOLD: begin
          if (!ce_s && !oe_s) begin
            doe_q <= 1'b1;
          end else begin
            doe_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_WAIT_REL: begin
          // Hold off until the write strobe is seen released, so one write
          // assertion yields one cycle.
          if (ce_s || we_s) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = wdat_q;
  assign wb_sel_o = '1;
  assign mem_wait = wait_q;
  assign mem_d_o  = rdat_q;
  assign mem_d_oe = doe_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_async_mem_sequencer.sv
// Bench for async_mem_sequencer: directed cases first, then random
// transactions. A Wishbone slave with a word-addressed memory model answers
// the DUT's bus cycles.
module tb_async_mem_sequencer;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ce_n, mem_we_n, mem_oe_n;
  logic [31:0] mem_addr, mem_d_i, mem_d_o;
  logic        mem_d_oe, mem_wait;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, err_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [logic [31:0]];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  async_mem_sequencer #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_ce_n(mem_ce_n), .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n),
    .mem_addr(mem_addr), .mem_d_i(mem_d_i),
    .mem_d_o(mem_d_o), .mem_d_oe(mem_d_oe), .mem_wait(mem_wait),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory contents the slave returns; unwritten words read as ~address.
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return model.exists(a) ? model[a] : ~a;
  endfunction

  // One master access. mode: 0 = ack, 1 = err, 2 = no response (timeout).
  // w = slave wait cycles before ack/err, and the read hold time.
  task automatic xact(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                      input int w, input int mode, input bit both_low, input bit viol);
    int          n;
    int          hi;
    int          cnt;
    logic [31:0] exp_rd;
    @(negedge clk);
    mem_addr = a;
    mem_d_i  = d;
    mem_ce_n = 1'b0;
    mem_we_n = !is_wr;
    mem_oe_n = is_wr && !both_low;
    // Strobe set before E0; cyc is visible after E2, the third edge.
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_cyc_o && n < 10);
    chk("strobe_to_cyc", 32'(n), 32'd3);
    chk("stb_up", 32'(wb_stb_o), 32'd1);
    chk("wait_up", 32'(mem_wait), 32'd1);
    chk("adr", wb_adr_o, a);
    chk("we", 32'(wb_we_o), 32'(is_wr));
    chk("sel", 32'(wb_sel_o), 32'hF);
    if (is_wr) chk("wdat", wb_dat_o, d);
    if (viol) mem_oe_n = 1'b1;
    hi = 0;
    while (wb_cyc_o && hi < 60) begin
      hi++;
      wb_ack_i = (mode == 0) && (hi == w + 1);
      wb_err_i = (mode == 1) && (hi == w + 1);
      wb_dat_i = wb_ack_i ? rd_model(wb_adr_o) : $urandom;
      @(negedge clk);
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = $urandom;
    chk("cyc_len", 32'(hi), 32'((mode == 2) ? TIMEOUT : w + 1));
    chk("wait_drop", 32'(mem_wait), 32'd0);
    chk("stb_drop", 32'(wb_stb_o), 32'd0);
    chk("err_pulse", 32'(err_o), 32'(mode != 0));
    if (is_wr) begin
      if (mode == 0) model[a] = d;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (k == 0) chk("err_clear", 32'(err_o), 32'd0);
        if (wb_cyc_o) cnt++;
      end
      chk("single_cycle", 32'(cnt), 32'd0);
    end else if (viol) begin
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (mem_d_oe || wb_cyc_o) cnt++;
      end
      chk("viol_no_oe", 32'(cnt), 32'd0);
      chk("viol_dout", mem_d_o, last_rd);
    end else begin
      exp_rd  = (mode == 0) ? rd_model(a) : 32'hFFFF_FFFF;
      last_rd = exp_rd;
      chk("rdata", mem_d_o, exp_rd);
      chk("doe_late", 32'(mem_d_oe), 32'd0);
      @(negedge clk);
      chk("doe_up", 32'(mem_d_oe), 32'd1);
      chk("err_clear", 32'(err_o), 32'd0);
      repeat (w) @(negedge clk);
      chk("rdata_hold", mem_d_o, exp_rd);
      if ($urandom_range(0, 1) == 1) mem_oe_n = 1'b1;
      else mem_ce_n = 1'b1;
      // Release before F0; resynced at F1; output enable drops at F2.
      n = 0;
      do begin @(negedge clk); n++; end while (mem_d_oe && n < 10);
      chk("doe_fall", 32'(n), 32'd3);
    end
    mem_ce_n = 1'b1;
    mem_we_n = 1'b1;
    mem_oe_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("xact wr=%0d adr=%h mode=%0d wait=%0d cyc_len=%0d", is_wr, a, mode, w, hi);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    int r;
    int mode;
    rst_n    = 1'b0;
    mem_ce_n = 1'b1;
    mem_we_n = 1'b1;
    mem_oe_n = 1'b1;
    mem_addr = '0;
    mem_d_i  = '0;
    wb_dat_i = '0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    last_rd  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_wait", 32'(mem_wait), 32'd0);
    chk("rst_doe", 32'(mem_d_oe), 32'd0);
    chk("rst_dout", mem_d_o, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_wdat", wb_dat_o, 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'hF);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Directed cases
    model[32'h80] = 32'hCAFE_F00D;
    xact(1'b1, 32'h40, 32'h1234_5678, 1, 0, 1'b0, 1'b0);
    xact(1'b0, 32'h80, 32'h0, 2, 0, 1'b0, 1'b0);
    xact(1'b0, 32'h40, 32'h0, 0, 0, 1'b0, 1'b0);
    xact(1'b0, 32'h44, 32'h0, 1, 2, 1'b0, 1'b0);
    xact(1'b1, 32'h48, 32'hAAAA_5555, 0, 2, 1'b0, 1'b0);
    xact(1'b1, 32'h4C, 32'h0BAD_0BAD, 2, 1, 1'b0, 1'b0);
    xact(1'b0, 32'h4C, 32'h0, 0, 0, 1'b0, 1'b0);
    xact(1'b1, 32'h50, 32'h5150_5150, 0, 0, 1'b1, 1'b0);
    xact(1'b0, 32'h50, 32'h0, 4, 0, 1'b0, 1'b1);

    // Reset asserted mid read cycle
    @(negedge clk);
    mem_addr = 32'h88;
    mem_ce_n = 1'b0;
    mem_oe_n = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_cyc_o && n < 10);
    chk("rst_mid_start", 32'(n), 32'd3);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_mid_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_mid_wait", 32'(mem_wait), 32'd0);
    chk("rst_mid_doe", 32'(mem_d_oe), 32'd0);
    chk("rst_mid_dout", mem_d_o, 32'd0);
    last_rd  = '0;
    mem_ce_n = 1'b1;
    mem_oe_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (wb_cyc_o || mem_wait) cnt++;
    end
    chk("rst_no_resume", 32'(cnt), 32'd0);
    $display("reset mid read cycle done");

    // Random accesses
    for (int i = 0; i < 20; i++) begin
      r    = int'($urandom_range(0, 9));
      mode = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
      xact(1'($urandom_range(0, 1)), 32'h40 + 32'(4 * $urandom_range(0, 16)),
           $urandom, int'($urandom_range(0, 5)), mode, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
